// File: rtl/relu_maxpool_feeder_pkg.sv
// relu_pool_pkg: register map, STATUS layout and FP32 ReLU helper shared by the
// ReLU + 2x2 max-pool feeder.
package relu_pool_pkg;

    localparam logic [31:0] DEF_BASE_ADDR = 32'hC441_0000;

    localparam logic [3:0] OFF_IN     = 4'h0;
    localparam logic [3:0] OFF_OUT    = 4'h4;
    localparam logic [3:0] OFF_STATUS = 4'h8;
    localparam logic [3:0] OFF_CLEAR  = 4'hC;

    localparam int ST_DONE = 0;
    localparam int ST_OVF  = 1;
    localparam int ST_UDF  = 2;
    localparam int ST_LVL  = 8;
    localparam int ST_CNT  = 16;

    // Any value with the sign bit set, including -0.0, collapses to +0.0.
    function automatic logic [31:0] relu(input logic [31:0] v);
        return v[31] ? 32'h0 : v;
    endfunction

endpackage

// File: rtl/relu_maxpool_feeder_if.sv
// relu_maxpool_feeder_if: single-cycle device-bus access with registered ack and read data.
interface relu_maxpool_feeder_if #(parameter int XLEN = 32);

    logic            en_i;
    logic            we_i;
    logic [XLEN-1:0] addr_i;
    logic [XLEN-1:0] data_i;
    logic            ready_o;
    logic [XLEN-1:0] data_o;

    modport master (output en_i, we_i, addr_i, data_i, input ready_o, data_o);
    modport slave  (input en_i, we_i, addr_i, data_i, output ready_o, data_o);

endinterface

// File: rtl/relu_maxpool_feeder_max2.sv
// fp_relu_max2: ReLU on both operands, then max; with the sign bit cleared the
// FP32 ordering equals an unsigned compare of bits[30:0], so +NaN wins.
module fp_relu_max2
    import relu_pool_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] y_o
);

    logic [31:0] ra, rb;

    assign ra  = relu(a_i);
    assign rb  = relu(b_i);
    assign y_o = (ra[30:0] >= rb[30:0]) ? ra : rb;

endmodule

// File: rtl/relu_maxpool_feeder.sv
// relu_maxpool_feeder: accepts an IN_W x IN_W FP32 map in raster order, applies
// ReLU and 2x2/stride-2 max-pool on the fly, and queues the pooled map for readback.
module relu_maxpool_feeder
    import relu_pool_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] BASE_ADDR = XLEN'(DEF_BASE_ADDR),
    parameter int              IN_W      = 8
)
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    relu_maxpool_feeder_if.slave bus
);

    localparam int N_IN  = IN_W * IN_W;
    localparam int N_OUT = N_IN / 4;
    localparam int HW    = IN_W / 2;
    localparam int CW    = $clog2(N_IN + 1);
    localparam int OW    = $clog2(N_OUT + 1);
    localparam int MW    = $clog2(N_OUT);
    localparam int RW    = $clog2(HW);

    logic [CW-1:0]   in_cnt_q, in_cnt_d;
    logic [OW-1:0]   out_wr_q, out_wr_d, out_rd_q, out_rd_d;
    logic [31:0]     hold_q, hold_d;
    logic            ovf_q, ovf_d, udf_q, udf_d;
    logic            ready_q;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic [31:0]     rowbuf_q [HW];
    logic [31:0]     out_mem_q [N_OUT];

    logic            hit, has_out, rb_we, om_we;
    logic [3:0]      off;
    logic [CW-1:0]   row, col;
    logic [RW-1:0]   rb_idx;
    logic [31:0]     pair, quad;
    logic [XLEN-1:0] status;

    assign hit     = bus.en_i && (bus.addr_i[XLEN-1:4] == BASE_ADDR[XLEN-1:4]);
    assign off     = bus.addr_i[3:0];
    assign row     = CW'(in_cnt_q / IN_W);
    assign col     = CW'(in_cnt_q % IN_W);
    assign rb_idx  = RW'(col >> 1);
    assign has_out = out_rd_q < out_wr_q;

    // Horizontal pair (hold, incoming) first, then merged with the upper row's pair.
    fp_relu_max2 u_row (.a_i(hold_q),           .b_i(bus.data_i), .y_o(pair));
    fp_relu_max2 u_col (.a_i(rowbuf_q[rb_idx]), .b_i(pair),       .y_o(quad));

    always_comb begin
        status               = '0;
        status[ST_DONE]      = out_wr_q == OW'(N_OUT);
        status[ST_OVF]       = ovf_q;
        status[ST_UDF]       = udf_q;
        status[ST_LVL +: OW] = out_wr_q - out_rd_q;
        status[ST_CNT +: CW] = in_cnt_q;
    end

    always_comb begin
        in_cnt_d = in_cnt_q;
        out_wr_d = out_wr_q;
        out_rd_d = out_rd_q;
        hold_d   = hold_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        rdata_d  = rdata_q;
        rb_we    = 1'b0;
        om_we    = 1'b0;
        if (hit && bus.we_i && off == OFF_IN) begin
            if (in_cnt_q == CW'(N_IN)) begin
                ovf_d = 1'b1;
            end else begin
                in_cnt_d = in_cnt_q + CW'(1);
                if (!col[0]) begin
                    hold_d = relu(bus.data_i);
                end else if (!row[0]) begin
                    rb_we = 1'b1;
                end else begin
                    om_we    = 1'b1;
                    out_wr_d = out_wr_q + OW'(1);
                end
            end
        end
        if (hit && bus.we_i && off == OFF_CLEAR) begin
            in_cnt_d = '0;
            out_wr_d = '0;
            out_rd_d = '0;
            hold_d   = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end
        if (hit && !bus.we_i) begin
            rdata_d = (off == OFF_OUT)    ? (has_out ? out_mem_q[out_rd_q[MW-1:0]] : '0) :
                      (off == OFF_STATUS) ? status : '0;
            if (off == OFF_OUT) begin
                out_rd_d = has_out ? out_rd_q + OW'(1) : out_rd_q;
                udf_d    = udf_q | !has_out;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            in_cnt_q <= '0;
            out_wr_q <= '0;
            out_rd_q <= '0;
            hold_q   <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            ready_q  <= 1'b0;
            rdata_q  <= '0;
        end else begin
            in_cnt_q <= in_cnt_d;
            out_wr_q <= out_wr_d;
            out_rd_q <= out_rd_d;
            hold_q   <= hold_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            ready_q  <= hit;
            rdata_q  <= rdata_d;
        end
    end

    // Pooling storage keeps its contents across reset and CLEAR.
    always_ff @(posedge clk_i) begin
        if (rb_we) rowbuf_q[rb_idx] <= pair;
        if (om_we) out_mem_q[out_wr_q[MW-1:0]] <= quad;
    end

    assign bus.ready_o = ready_q;
    assign bus.data_o  = rdata_q;

endmodule

// File: tb/tb_relu_maxpool_feeder.sv
// tb_relu_maxpool_feeder: directed register-level test of ReLU + 2x2 max-pool feeder.
module tb_relu_maxpool_feeder;

    localparam logic [31:0] BASE  = 32'hC441_0000;
    localparam logic [31:0] A_IN  = BASE + 32'h0;
    localparam logic [31:0] A_OUT = BASE + 32'h4;
    localparam logic [31:0] A_ST  = BASE + 32'h8;
    localparam logic [31:0] A_CLR = BASE + 32'hC;
    localparam logic [31:0] ONE   = 32'h3F80_0000;
    localparam logic [31:0] THREE = 32'h4040_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] q;
    int          n_chk = 0;
    int          n_fail = 0;

    relu_maxpool_feeder_if #(.XLEN(32)) bus ();

    relu_maxpool_feeder dut (.clk_i(clk), .rst_i(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One bus access; returns in the ack cycle, so consecutive calls are back-to-back.
    task automatic acc(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic exp_rdy, output logic [31:0] rd);
        bus.en_i   = 1'b1;
        bus.we_i   = w;
        bus.addr_i = a;
        bus.data_i = d;
        @(posedge clk);
        #1;
        chk("ready", {31'b0, bus.ready_o}, {31'b0, exp_rdy});
        rd = bus.data_o;
        bus.en_i = 1'b0;
    endtask

    function automatic logic [31:0] f2b(input int i);
        int e;
        logic [31:0] m;
        if (i == 0) return 32'h0;
        e = 0;
        for (int b = 0; b < 31; b++) if (i[b]) e = b;
        m = 32'(i) << (23 - e);
        return {1'b0, 8'(127 + e), m[22:0]};
    endfunction

    initial begin
        bus.en_i = 1'b0;
        bus.we_i = 1'b0;
        bus.addr_i = '0;
        bus.data_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'b0, bus.ready_o}, 32'h0);
        chk("rst_data", bus.data_o, 32'h0);
        rst_n = 1'b1;
        acc(1'b0, A_ST, 0, 1'b1, q);
        chk("rst_status", q, 32'h0);

        // Map of 1.0 with 3.0 at r=1,c=1
        for (int i = 0; i < 64; i++) acc(1'b1, A_IN, (i == 9) ? THREE : ONE, 1'b1, q);
        acc(1'b0, A_ST, 0, 1'b1, q);
        chk("full_status", q, 32'h0040_1001);
        for (int k = 0; k < 16; k++) begin
            acc(1'b0, A_OUT, 0, 1'b1, q);
            chk($sformatf("ones_out%0d", k), q, (k == 0) ? THREE : ONE);
        end
        acc(1'b0, A_ST, 0, 1'b1, q);
        chk("drained_status", q, 32'h0040_0001);

        // Overflow, underflow, no-effect accesses, CLEAR
        acc(1'b1, A_IN, 32'h7F00_0000, 1'b1, q);
        acc(1'b0, A_ST, 0, 1'b1, q);
        chk("ovf_status", q, 32'h0040_0003);
        acc(1'b0, A_OUT, 0, 1'b1, q);
        chk("udf_read", q, 32'h0);
        acc(1'b0, A_ST, 0, 1'b1, q);
        chk("udf_status", q, 32'h0040_0007);
        acc(1'b1, A_ST, 32'hFFFF_FFFF, 1'b1, q);
        acc(1'b0, A_IN, 0, 1'b1, q);
        chk("read_in", q, 32'h0);
        acc(1'b0, A_ST, 0, 1'b1, q);
        chk("st_write_noeffect", q, 32'h0040_0007);
        acc(1'b1, A_CLR, 32'h1234_5678, 1'b1, q);
        acc(1'b0, A_CLR, 0, 1'b1, q);
        chk("read_clr", q, 32'h0);
        acc(1'b0, A_ST, 0, 1'b1, q);
        chk("clear_status", q, 32'h0);

        // All negative, with -0.0 sprinkled in
        for (int i = 0; i < 64; i++)
            acc(1'b1, A_IN, (i % 5 == 0 || i == 9) ? 32'h8000_0000 : 32'hBF80_0000, 1'b1, q);
        for (int k = 0; k < 16; k++) begin
            acc(1'b0, A_OUT, 0, 1'b1, q);
            chk($sformatf("neg_out%0d", k), q, 32'h0);
        end
        acc(1'b1, A_CLR, 0, 1'b1, q);

        // Raster float(i)
        for (int i = 0; i < 64; i++) acc(1'b1, A_IN, f2b(i), 1'b1, q);
        for (int k = 0; k < 16; k++) begin
            acc(1'b0, A_OUT, 0, 1'b1, q);
            chk($sformatf("raster_out%0d", k), q, f2b((2 * (k / 4) + 1) * 8 + 2 * (k % 4) + 1));
        end
        acc(1'b1, A_CLR, 0, 1'b1, q);

        // Asynchronous reset mid-map
        for (int i = 0; i < 37; i++) acc(1'b1, A_IN, ONE, 1'b1, q);
        acc(1'b0, A_ST, 0, 1'b1, q);
        chk("mid_status", q, 32'h0025_0800);
        #1 rst_n = 1'b0;
        #1;
        chk("async_ready", {31'b0, bus.ready_o}, 32'h0);
        chk("async_data", bus.data_o, 32'h0);
        #1 rst_n = 1'b1;
        acc(1'b0, A_ST, 0, 1'b1, q);
        chk("post_rst_status", q, 32'h0);

        // Back-to-back raster map with one unmapped access in the middle
        for (int i = 0; i < 64; i++) begin
            acc(1'b1, A_IN, f2b(i), 1'b1, q);
            if (i == 20) acc(1'b1, 32'hC442_0000, 32'hDEAD_BEEF, 1'b0, q);
        end
        acc(1'b0, A_ST, 0, 1'b1, q);
        chk("b2b_status", q, 32'h0040_1001);
        for (int k = 0; k < 16; k++) begin
            acc(1'b0, A_OUT, 0, 1'b1, q);
            chk($sformatf("b2b_out%0d", k), q, f2b((2 * (k / 4) + 1) * 8 + 2 * (k % 4) + 1));
        end
        acc(1'b0, A_ST, 0, 1'b1, q);
        chk("b2b_drained", q, 32'h0040_0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
